// File: rtl/vend_dispense_ctrl.sv
// Dispenser back-end for the vending_mealy FSM: queues vend/change pulses,
// runs the motor and coin-return solenoid, confirms drops and tracks stock.
module vend_dispense_ctrl #(
  parameter int MOTOR_CYCLES = 4,
  parameter int DROP_TIMEOUT = 16,
  parameter int RET_CYCLES   = 2,
  parameter int STOCK_INIT   = 8,
  parameter int SW           = 4,
  parameter int QW           = 3
) (
  input  logic          clk_sig,
  input  logic          reset,
  input  logic          item_out,
  input  logic          return5,
  input  logic          item_drop,
  input  logic          restock,
  input  logic          clear_fault,
  output logic          motor_en,
  output logic          coin_ret,
  output logic [SW-1:0] stock,
  output logic          sold_out,
  output logic          busy,
  output logic          fault,
  output logic          ovf
);

  // One shared timer serves the motor, drop-wait and coin-return phases.
  localparam int TMAX0 = (MOTOR_CYCLES > DROP_TIMEOUT) ? MOTOR_CYCLES : DROP_TIMEOUT;
  localparam int TMAX  = (TMAX0 > RET_CYCLES) ? TMAX0 : RET_CYCLES;
  localparam int TW    = (TMAX > 1) ? $clog2(TMAX) : 1;
  // Two guard bits so +1 and +3 can be detected past the counter ceiling.
  localparam int CW    = QW + 2;

  localparam logic [QW-1:0] QMAX      = '1;
  localparam logic [SW-1:0] STOCK_RST = SW'(STOCK_INIT);

  typedef enum logic [2:0] {IDLE, MOTOR, WAIT_DROP, RETURN, FAULT} state_t;

  state_t        state;
  logic [QW-1:0] item_pend;
  logic [QW-1:0] ret_pend;
  logic [TW-1:0] timer;
  logic          drop_seen;

  logic          item_dec;
  logic          ret_dec;
  logic          refund;
  logic [CW-1:0] item_sum;
  logic [CW-1:0] ret_sum;
  logic [QW-1:0] item_pend_next;
  logic [QW-1:0] ret_pend_next;
  logic          item_lost;
  logic          ret_lost;

  // Which pending counters the FSM consumes this cycle.
  always_comb begin
    item_dec = 1'b0;
    ret_dec  = 1'b0;
    refund   = 1'b0;
    case (state)
      IDLE: begin
        if (item_pend != '0 && stock == '0) begin
          item_dec = 1'b1;
          refund   = 1'b1;
        end
      end
      WAIT_DROP: begin
        if (drop_seen || item_drop) item_dec = 1'b1;
      end
      RETURN: begin
        if (timer == TW'(RET_CYCLES - 1)) ret_dec = 1'b1;
      end
      default: ;
    endcase
  end

  // Net counter update (capture minus consume, plus 3 coins per refund), clamped at the ceiling.
  always_comb begin
    item_sum       = CW'(item_pend) + CW'(item_out) - CW'(item_dec);
    ret_sum        = CW'(ret_pend) + CW'(return5) + (refund ? CW'(3) : CW'(0)) - CW'(ret_dec);
    item_lost      = (item_sum > CW'(QMAX));
    ret_lost       = (ret_sum > CW'(QMAX));
    item_pend_next = item_lost ? QMAX : item_sum[QW-1:0];
    ret_pend_next  = ret_lost ? QMAX : ret_sum[QW-1:0];
  end

  assign busy = (state != IDLE) || (item_pend != '0) || (ret_pend != '0);

  // Main FSM with registered drive outputs, queue counters and stock.
  always_ff @(posedge clk_sig or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      item_pend <= '0;
      ret_pend  <= '0;
      timer     <= '0;
      drop_seen <= 1'b0;
      stock     <= STOCK_RST;
      sold_out  <= (STOCK_INIT == 0);
      motor_en  <= 1'b0;
      coin_ret  <= 1'b0;
      fault     <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      item_pend <= item_pend_next;
      ret_pend  <= ret_pend_next;
      ovf       <= ovf | item_lost | ret_lost;
      sold_out  <= (stock == '0);

      case (state)
        IDLE: begin
          if (item_pend != '0 && stock != '0) begin
            state     <= MOTOR;
            motor_en  <= 1'b1;
            timer     <= '0;
            drop_seen <= 1'b0;
          end else if (item_pend == '0 && ret_pend != '0) begin
            state    <= RETURN;
            coin_ret <= 1'b1;
            timer    <= '0;
          end
        end
        MOTOR: begin
          if (item_drop) drop_seen <= 1'b1;
          if (timer == TW'(MOTOR_CYCLES - 1)) begin
            state    <= WAIT_DROP;
            motor_en <= 1'b0;
            timer    <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        WAIT_DROP: begin
          if (item_dec) begin
            if (stock != '0) stock <= stock - SW'(1);
            state     <= IDLE;
            drop_seen <= 1'b0;
            timer     <= '0;
          end else if (timer == TW'(DROP_TIMEOUT - 1)) begin
            state <= FAULT;
            fault <= 1'b1;
            timer <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        RETURN: begin
          if (ret_dec) begin
            state    <= IDLE;
            coin_ret <= 1'b0;
            timer    <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        FAULT: begin
          motor_en <= 1'b0;
          coin_ret <= 1'b0;
          if (clear_fault) begin
            state     <= IDLE;
            fault     <= 1'b0;
            timer     <= '0;
            drop_seen <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      // Restock overrides any vend decrement on the same edge.
      if (restock) stock <= STOCK_RST;
    end
  end

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Bench for vend_dispense_ctrl: table of vend/return scenarios plus hand
// sequences for latency, fault timeout, refund, saturation and async reset.
module tb_vend_dispense_ctrl;

  localparam int MC = 4;
  localparam int RC = 2;

  logic       clk_sig = 1'b0;
  logic       reset = 1'b0;
  logic       item_out = 1'b0;
  logic       return5 = 1'b0;
  logic       item_drop = 1'b0;
  logic       restock = 1'b0;
  logic       clear_fault = 1'b0;

  logic       motor_en, coin_ret, sold_out, busy, fault, ovf;
  logic [3:0] stock;
  logic       s1_motor_en, s1_coin_ret, s1_sold_out, s1_busy, s1_fault, s1_ovf;
  logic [3:0] s1_stock;

  always #5 clk_sig = ~clk_sig;

  vend_dispense_ctrl dut (
    .clk_sig(clk_sig), .reset(reset), .item_out(item_out), .return5(return5),
    .item_drop(item_drop), .restock(restock), .clear_fault(clear_fault),
    .motor_en(motor_en), .coin_ret(coin_ret), .stock(stock), .sold_out(sold_out),
    .busy(busy), .fault(fault), .ovf(ovf)
  );

  // Single-item stock variant for the sold-out refund path.
  vend_dispense_ctrl #(.STOCK_INIT(1)) dut_s1 (
    .clk_sig(clk_sig), .reset(reset), .item_out(item_out), .return5(return5),
    .item_drop(item_drop), .restock(restock), .clear_fault(clear_fault),
    .motor_en(s1_motor_en), .coin_ret(s1_coin_ret), .stock(s1_stock), .sold_out(s1_sold_out),
    .busy(s1_busy), .fault(s1_fault), .ovf(s1_ovf)
  );

  int errors = 0;
  int checks = 0;

  // Scoreboard: expected pulse lengths, pushed when the request is driven.
  int motor_q[$];
  int coin_q[$];

  // Drop responder: -1 manual, 0 hold high, 1..16 pulse N cycles after motor falls, 99 never.
  int drop_mode = -1;
  int drop_cnt = 0;

  bit m_prev = 0, c_prev = 0, m_fell = 0;
  int m_len = 0, c_len = 0;
  bit s1m_prev = 0, s1c_prev = 0;
  int s1_mrise = 0, s1_crise = 0, s1_chigh = 0;

  typedef struct {
    int n_item; int n_ret; int drop;
    int n_motor; int n_coin; int exp_stock; int exp_fault; int exp_busy;
  } row_t;
  row_t rows[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, what);
  endtask

  task automatic pulse_done(input bit is_coin, input int len);
    int exp;
    if (is_coin) begin
      if (coin_q.size() == 0) begin
        fail_now("coin pulse", $sformatf("unexpected pulse of %0d cycles", len));
        return;
      end
      exp = coin_q.pop_front();
      chk("coin pulse length", len, exp);
    end else begin
      if (motor_q.size() == 0) begin
        fail_now("motor pulse", $sformatf("unexpected pulse of %0d cycles", len));
        return;
      end
      exp = motor_q.pop_front();
      chk("motor pulse length", len, exp);
    end
  endtask

  // Advance one cycle; sample outputs on the falling edge, monitor pulses, run drop responder.
  task automatic tick();
    @(negedge clk_sig);
    m_fell = 0;
    if (!reset) begin
      m_prev = 0; c_prev = 0; m_len = 0; c_len = 0; drop_cnt = 0;
      s1m_prev = 0; s1c_prev = 0;
      return;
    end
    if (motor_en) m_len++;
    else if (m_prev) begin
      pulse_done(1'b0, m_len);
      m_len = 0;
      m_fell = 1;
      if (drop_mode > 0 && drop_mode < 99) drop_cnt = drop_mode;
    end
    m_prev = motor_en;
    if (coin_ret) c_len++;
    else if (c_prev) begin
      pulse_done(1'b1, c_len);
      c_len = 0;
    end
    c_prev = coin_ret;
    if (s1_motor_en && !s1m_prev) s1_mrise++;
    if (s1_coin_ret && !s1c_prev) s1_crise++;
    if (s1_coin_ret) s1_chigh++;
    s1m_prev = s1_motor_en;
    s1c_prev = s1_coin_ret;
    if (drop_mode > 0) item_drop = 1'b0;
    if (drop_cnt > 0) begin
      drop_cnt--;
      if (drop_cnt == 0) item_drop = 1'b1;
    end
  endtask

  task automatic do_reset();
    item_out = 0; return5 = 0; item_drop = 0; restock = 0; clear_fault = 0;
    drop_mode = -1; drop_cnt = 0;
    reset = 1'b0;
    tick();
    tick();
    motor_q.delete();
    coin_q.delete();
    reset = 1'b1;
    tick();
  endtask

  // Wait until the controller drains (or faults); an expired budget is a failure.
  task automatic wait_done(input string name, input int limit, input bit inc_s1);
    int n = 0;
    while (!((!busy || fault) && (!inc_s1 || !s1_busy)) && n < limit) begin
      tick();
      n++;
    end
    if (n >= limit) fail_now(name, "timeout waiting for idle");
  endtask

  task automatic run_row(input int idx);
    row_t r;
    int nmax;
    r = rows[idx];
    do_reset();
    drop_mode = r.drop;
    if (r.drop == 0) item_drop = 1'b1;
    nmax = (r.n_item > r.n_ret) ? r.n_item : r.n_ret;
    for (int i = 0; i < nmax; i++) begin
      item_out = (i < r.n_item);
      return5  = (i < r.n_ret);
      if (i < r.n_item && i < r.n_motor) motor_q.push_back(MC);
      if (i < r.n_ret && i < r.n_coin) coin_q.push_back(RC);
      tick();
    end
    item_out = 0;
    return5  = 0;
    wait_done($sformatf("row%0d", idx), 400, 1'b0);
    tick();
    chk($sformatf("row%0d motor pulses left", idx), motor_q.size(), 0);
    chk($sformatf("row%0d coin pulses left", idx), coin_q.size(), 0);
    chk($sformatf("row%0d stock", idx), int'(stock), r.exp_stock);
    chk($sformatf("row%0d fault", idx), int'(fault), r.exp_fault);
    chk($sformatf("row%0d busy", idx), int'(busy), r.exp_busy);
    chk($sformatf("row%0d sold_out", idx), int'(sold_out), (r.exp_stock == 0) ? 1 : 0);
    chk($sformatf("row%0d ovf", idx), int'(ovf), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    //          items rets drop  mot coin stock fault busy
    rows[0] = '{1,    0,   2,    1,  0,   7,    0,    0};
    rows[1] = '{1,    1,   2,    1,  1,   7,    0,    0};
    rows[2] = '{0,    3,   2,    0,  3,   8,    0,    0};
    rows[3] = '{3,    0,   0,    3,  0,   5,    0,    0};
    rows[4] = '{2,    2,   16,   2,  2,   6,    0,    0};
    rows[5] = '{1,    2,   99,   1,  0,   8,    1,    1};
    rows[6] = '{6,    1,   1,    6,  1,   2,    0,    0};
    rows[7] = '{0,    0,   2,    0,  0,   8,    0,    0};

    // Reset state, sampled while reset is held low.
    tick();
    chk("reset motor_en", int'(motor_en), 0);
    chk("reset coin_ret", int'(coin_ret), 0);
    chk("reset stock", int'(stock), 8);
    chk("reset sold_out", int'(sold_out), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset fault", int'(fault), 0);
    chk("reset ovf", int'(ovf), 0);
    chk("reset s1 stock", int'(s1_stock), 1);

    for (int i = 0; i < 8; i++) run_row(i);

    // Latency, drop timeout into FAULT, capture during FAULT, recovery.
    do_reset();
    item_out = 1; motor_q.push_back(MC); tick(); item_out = 0;
    chk("t5 busy after capture", int'(busy), 1);
    chk("t5 motor_en at capture edge", int'(motor_en), 0);
    tick();
    chk("t5 motor_en one edge later", int'(motor_en), 1);
    n = 0;
    while (!m_fell && n < 20) begin tick(); n++; end
    if (!m_fell) fail_now("t5 motor fall", "motor_en never fell");
    repeat (15) tick();
    chk("t5 fault before timeout", int'(fault), 0);
    tick();
    chk("t5 fault at timeout", int'(fault), 1);
    chk("t5 stock unchanged", int'(stock), 8);
    return5 = 1; coin_q.push_back(RC); tick(); return5 = 0;
    tick();
    chk("t5 coin_ret held off in fault", int'(coin_ret), 0);
    chk("t5 still faulted", int'(fault), 1);
    drop_mode = 3;
    motor_q.push_back(MC);
    clear_fault = 1; tick(); clear_fault = 0;
    chk("t5 fault cleared", int'(fault), 0);
    wait_done("t5 recovery", 200, 1'b0);
    tick();
    chk("t5 stock after recovery", int'(stock), 7);
    chk("t5 busy after recovery", int'(busy), 0);
    chk("t5 queues drained", motor_q.size() + coin_q.size(), 0);

    // Sold-out refund on the single-stock instance, then restock.
    do_reset();
    drop_mode = 2; s1_mrise = 0; s1_crise = 0; s1_chigh = 0;
    item_out = 1; motor_q.push_back(MC); tick(); item_out = 0;
    wait_done("t4 first vend", 200, 1'b1);
    tick();
    chk("t4 s1 stock", int'(s1_stock), 0);
    chk("t4 s1 sold_out", int'(s1_sold_out), 1);
    chk("t4 stock", int'(stock), 7);
    item_out = 1; motor_q.push_back(MC); tick(); item_out = 0;
    wait_done("t4 refund", 300, 1'b1);
    tick();
    chk("t4 s1 motor pulses", s1_mrise, 1);
    chk("t4 s1 coin pulses", s1_crise, 3);
    chk("t4 s1 coin high cycles", s1_chigh, 6);
    chk("t4 s1 ovf", int'(s1_ovf), 0);
    chk("t4 s1 fault", int'(s1_fault), 0);
    chk("t4 stock after two vends", int'(stock), 6);
    restock = 1; tick(); restock = 0;
    chk("t4 s1 restocked", int'(s1_stock), 1);
    chk("t4 s1 sold_out lags", int'(s1_sold_out), 1);
    tick();
    chk("t4 s1 sold_out cleared", int'(s1_sold_out), 0);
    chk("t4 stock restocked", int'(stock), 8);

    // Saturation while in FAULT, then mid-MOTOR asynchronous reset.
    do_reset();
    item_out = 1; motor_q.push_back(MC); tick(); item_out = 0;
    wait_done("t6 to fault", 100, 1'b0);
    chk("t6 in fault", int'(fault), 1);
    item_out = 1;
    repeat (6) tick();
    item_out = 0;
    tick();
    chk("t6 ovf at ceiling", int'(ovf), 0);
    item_out = 1; tick(); item_out = 0;
    tick();
    chk("t6 ovf after loss", int'(ovf), 1);
    item_out = 1; tick(); item_out = 0;
    item_drop = 1;
    repeat (7) motor_q.push_back(MC);
    clear_fault = 1; tick(); clear_fault = 0;
    wait_done("t6 drain", 400, 1'b0);
    tick();
    chk("t6 stock after 7 vends", int'(stock), 1);
    chk("t6 busy", int'(busy), 0);
    chk("t6 ovf sticky", int'(ovf), 1);
    chk("t6 queues drained", motor_q.size() + coin_q.size(), 0);
    item_drop = 0;
    item_out = 1; motor_q.push_back(MC); tick(); item_out = 0;
    tick();
    tick();
    chk("t6 motor running", int'(motor_en), 1);
    #2 reset = 1'b0;
    #1;
    chk("t6 async motor_en", int'(motor_en), 0);
    chk("t6 async stock", int'(stock), 8);
    chk("t6 async busy", int'(busy), 0);
    chk("t6 async ovf", int'(ovf), 0);
    motor_q.delete();
    coin_q.delete();
    tick();
    reset = 1'b1;
    tick();
    tick();
    chk("t6 idle after reset", int'(motor_en) + int'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
